// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN datapath: token width, default channel
// depth and the token type used by the multiplier and adder channels.
package kpn_pkg;

  localparam int KPN_TOKEN_WIDTH        = 32;
  localparam int KPN_FIFO_DEPTH_DEFAULT = 8;

  typedef logic [KPN_TOKEN_WIDTH-1:0] kpn_token_t;

endpackage

// File: rtl/kpn_fifo_mem.sv
// Token storage for kpn_fifo_channel: DEPTH x DATA_WIDTH array with one
// synchronous write port and one synchronous read port. The read register
// doubles as the channel's data_out, so it is the only part that is reset;
// the array itself is left unreset so it maps onto block RAM.
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_TOKEN_WIDTH,
  parameter int DEPTH      = KPN_FIFO_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the token on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: load the addressed token on an accepted read, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded FIFO channel between KPN processes with blocking semantics:
// the producer stalls on full, the consumer stalls on empty, and no token
// is lost or duplicated. Optional sticky overflow/underflow flags are
// compiled in with KPN_FIFO_ERR_FLAGS_EN.
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = KPN_TOKEN_WIDTH,
  parameter int DEPTH      = KPN_FIFO_DEPTH_DEFAULT,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef KPN_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  // One extra pointer bit distinguishes full from empty when the low
  // address bits coincide.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_en;
  logic                rd_en;

  // Blocked requests are simply not accepted; at full only the read can
  // proceed and at empty only the write can, so there is no fall-through.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  // Status comes straight from the registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign count = wr_ptr - rd_ptr;

  // Pointer advance on accepted transfers; wraps modulo 2*DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef KPN_FIFO_ERR_FLAGS_EN
  // Sticky error flags: record any request made against a blocking boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full)  overflow  <= 1'b1;
      if (rd & empty) underflow <= 1'b1;
    end
  end
`endif

  kpn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .we    (wr_en),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (rd_en),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Testbench for kpn_fifo_channel (DEPTH=8, 32-bit tokens). A queue of
// written tokens serves as the reference; a small vector table covers the
// ordering case, hand-written sequences cover the boundaries.
module tb_kpn_fifo_channel;
  import kpn_pkg::*;

  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  kpn_token_t       data_in = '0;
  kpn_token_t       data_out;
  logic             full;
  logic             empty;
  logic [3:0]       count;
`ifdef KPN_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  kpn_fifo_channel #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .data_in  (data_in),
    .full     (full),
    .rd       (rd),
    .data_out (data_out),
    .empty    (empty),
    .count    (count)
`ifdef KPN_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  kpn_token_t model_q[$];
  kpn_token_t exp_dout = '0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  typedef struct {
    logic       w;
    kpn_token_t d;
    logic       r;
    kpn_token_t dout;
    int         cnt;
    logic       emp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".data_out"}, data_out, exp_dout);
    chk({tag, ".count"}, 32'(count), 32'(model_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(model_q.size() == DEPTH));
`ifdef KPN_FIFO_ERR_FLAGS_EN
    chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic do_cycle(input string tag, input logic w, input kpn_token_t d, input logic r);
    int sz;
    sz = model_q.size();
    wr = w;
    data_in = d;
    rd = r;
    if (w && sz == DEPTH) exp_ovf = 1'b1;
    if (r && sz == 0) exp_unf = 1'b1;
    if (r && sz > 0) exp_dout = model_q.pop_front();
    if (w && sz < DEPTH) model_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    $display("txn %s wr=%0d din=%h rd=%0d -> dout=%h count=%0d empty=%0d full=%0d",
             tag, w, d, r, data_out, count, empty, full);
    check_state(tag);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h320, 1'b0, 32'h0,   1, 1'b0};
    vecs[1] = '{1'b1, 32'h400, 1'b0, 32'h0,   2, 1'b0};
    vecs[2] = '{1'b1, 32'h900, 1'b0, 32'h0,   3, 1'b0};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 32'h320, 2, 1'b0};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 32'h400, 1, 1'b0};
    vecs[5] = '{1'b0, 32'h0,   1'b1, 32'h900, 0, 1'b1};

    // Reset then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_state("reset");
    for (int i = 0; i < 3; i++) do_cycle("idle_rd", 1'b0, 32'h0, 1'b1);

    // Ordering, table driven
    for (int i = 0; i < 6; i++) begin
      do_cycle("order", vecs[i].w, vecs[i].d, vecs[i].r);
      chk("order.tbl_dout", data_out, vecs[i].dout);
      chk("order.tbl_count", 32'(count), 32'(vecs[i].cnt));
      chk("order.tbl_empty", 32'(empty), 32'(vecs[i].emp));
    end

    // Fill and overflow
    for (int i = 1; i <= 9; i++) begin
      do_cycle("fill", 1'b1, 32'(i), 1'b0);
      if (i >= 8) begin
        chk("fill.full_at_8", 32'(full), 32'h1);
        chk("fill.count_at_8", 32'(count), 32'h8);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      do_cycle("drain", 1'b0, 32'h0, 1'b1);
      chk("drain.token", data_out, 32'(i));
    end
    chk("drain.empty", 32'(empty), 32'h1);

    // Wrap with simultaneous access
    for (int i = 0; i < 4; i++) do_cycle("preload", 1'b1, 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_cycle("wrap", 1'b1, 32'h200 + 32'(i), 1'b1);
      chk("wrap.count", 32'(count), 32'h4);
      chk("wrap.token", data_out, (i < 4) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 4));
    end

    // Full boundary: top up to 8, then wr+rd accepts only the read
    for (int i = 0; i < 4; i++) do_cycle("topup", 1'b1, 32'h300 + 32'(i), 1'b0);
    chk("bound.full_before", 32'(full), 32'h1);
    do_cycle("bound", 1'b1, 32'hDEAD, 1'b1);
    chk("bound.count", 32'(count), 32'h7);
    chk("bound.full", 32'(full), 32'h0);
    chk("bound.token", data_out, 32'h210);

    // Reset mid-stream at count 5, between clock edges
    do_cycle("to5", 1'b0, 32'h0, 1'b1);
    do_cycle("to5", 1'b0, 32'h0, 1'b1);
    chk("mid.count5", 32'(count), 32'h5);
    #2 reset = 1'b1;
    model_q.delete();
    exp_dout = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    check_state("midrst");
    #1 reset = 1'b0;
    @(negedge clk);
    do_cycle("post_wr", 1'b1, 32'hABC, 1'b0);
    do_cycle("post_rd", 1'b0, 32'h0, 1'b1);
    chk("post.token", data_out, 32'hABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kpn_fifo_channel.md
# kpn_fifo_channel

Bounded FIFO channel for the KPN datapath. It sits directly downstream of the multiplier process and buffers its 32-bit product tokens until the next process reads them. It provides KPN blocking semantics in hardware: the producer stalls on `full` and the consumer stalls on `empty`. No token is ever lost or duplicated.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: token width; matches the multiplier `output_1` width.
- `DEPTH`, default 8: number of token slots; must be a power of two and at least 2.
- `ADDR_WIDTH`: local, equal to log2(DEPTH); not overridable.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `wr`  in  1  write request from the producer (multiplier `wr`).
- `data_in`  in  DATA_WIDTH  token to write (multiplier `output_1`).
- `full`  out  1  channel holds DEPTH tokens.
- `rd`  in  1  read request from the consumer.
- `data_out`  out  DATA_WIDTH  registered token popped by the last accepted read.
- `empty`  out  1  channel holds 0 tokens.
- `count`  out  ADDR_WIDTH+1  current occupancy, from 0 to DEPTH.
- `overflow`, `underflow`  out  1 each  present only with KPN_FIFO_ERR_FLAGS_EN.

## Operation
- A write is accepted when `wr & ~full`. On acceptance, `data_in` is stored at `wr_ptr` and `wr_ptr` increments.
- A read is accepted when `rd & ~empty`. On acceptance, the entry at `rd_ptr` is loaded into `data_out` and `rd_ptr` increments.
- A write while full is ignored: memory, pointers and `count` are unchanged.
- A read while empty is ignored: `data_out` holds its previous value.
- When both a write and a read are accepted in the same cycle, both take effect and `count` is unchanged. This is legal at any occupancy from 1 to DEPTH-1.
- When full, a simultaneous `wr` and `rd` accept only the read. The write is dropped, and the producer must hold `wr` and retry.
- When empty, a simultaneous `wr` and `rd` accept only the write. There is no fall-through.
- Pointers are ADDR_WIDTH+1 bits wide and wrap modulo 2·DEPTH. The low bits address memory.
- `empty` is asserted when the two pointers are equal.
- `full` is asserted when the pointer MSBs differ and the low bits are equal.
- `count` = `wr_ptr` − `rd_ptr`, taken modulo 2^(ADDR_WIDTH+1).
- `full`, `empty` and `count` are derived from the registered pointers, so they are glitch-free relative to `clk`.
- Tokens are opaque; no arithmetic is performed on them.

## Timing
- Reset values: `data_out`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0, both pointers 0. Memory contents are not reset.
- Asserting `reset` mid-operation discards all buffered tokens on the reset assertion itself, with no clock edge required.
- Write to status: a write accepted at edge N makes `empty` deassert and `count` update in cycle N+1.
- Read latency: with `rd` sampled at edge N, `data_out` is valid from edge N and holds until the next accepted read.
- Minimum write-to-read turnaround is 1 cycle: a token written at edge N can be popped at edge N+1.
- Sustained throughput is one token per cycle in each direction when not at a boundary.
- Status outputs reflect state after the current edge. `wr` and `rd` may be held high continuously.

## Configuration
- With `KPN_FIFO_ERR_FLAGS_EN` defined, the `overflow` and `underflow` ports exist.
  - `overflow` is set on any edge where `wr & full`.
  - `underflow` is set on any edge where `rd & empty`.
  - Both flags are sticky and cleared only by `reset`.
- Without `KPN_FIFO_ERR_FLAGS_EN`, those ports and their logic are absent, and blocked requests are silently ignored.

## Structure
- Shared package `kpn_pkg`:
  - `KPN_TOKEN_WIDTH`=32.
  - `KPN_FIFO_DEPTH_DEFAULT`=8.
  - A `kpn_token_t` typedef, reused by the multiplier and adder channels.
- One sub-module, `kpn_fifo_mem`: a DEPTH×DATA_WIDTH register array with a synchronous write port and a synchronous read port.
- Pointer, flag and count logic lives in `kpn_fifo_channel`.

## Test plan
- Reset then idle: after `reset` pulse, expect `empty`=1, `full`=0, `count`=0, `data_out`=0; hold `rd`=1 for 3 cycles and expect `data_out` to stay 0.
- Ordering: write 0x00000320, 0x00000400, 0x00000900 on consecutive edges, then read 3 times. Expect `data_out` 0x320, 0x400, 0x900 in order, then `empty`=1.
- Fill and overflow: write 9 tokens 0x1–0x9 with DEPTH=8. Expect `full`=1 and `count`=8 after the 8th write, token 0x9 dropped, `overflow`=1 when the flag is enabled, and readback 0x1–0x8.
- Wrap and simultaneous access: pre-load 4 tokens, then assert `wr`+`rd` for 20 cycles with incrementing data. Expect `count` to stay 4 and the output sequence to match the input delayed by 4 reads across the pointer wrap.
- Full boundary: at `count`=8, assert `wr`+`rd` in one cycle. Expect only the read accepted, `count`=7 and `full`=0.
- Reset mid-stream: with `count`=5, assert `reset` between clock edges. Expect `empty`=1, `count`=0 and `data_out`=0 immediately; the next write/read returns the new token.
